// File: rtl/shift_reg4_sipo.sv
// 4-bit serial-in/parallel-out shift register: clear > load > shift, A -> B -> C -> D -> E.
// Optional registered parity output P when SHIFTREG_PARITY_EN is defined.
module shift_reg4_sipo #(
  parameter logic [3:0] CLR_VALUE = 4'b0000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] data,
  input  logic       ena,
  input  logic       A,
`ifdef SHIFTREG_PARITY_EN
  output logic       P,
`endif
  output logic [3:0] Q,
  output logic       E
);

  function automatic logic even_parity(input logic [3:0] v);
    even_parity = ^v;
  endfunction

  logic [3:0] q_d;
  logic [3:0] q_q;
  logic       B;
  logic       C;
  logic       D;

  assign B = q_q[3];
  assign C = q_q[2];
  assign D = q_q[1];
  assign E = q_q[0];
  assign Q = q_q;

  // Next-state selection with clr > load > ena priority.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = CLR_VALUE;
    end else if (load) begin
      q_d = data;
    end else if (ena) begin
      q_d = {A, B, C, D};
    end else begin
      q_d = q_q;
    end
  end

  // Stage register.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

`ifdef SHIFTREG_PARITY_EN
  logic p_d;
  logic p_q;

  assign P = p_q;

  // Parity of the value the stages take on this edge.
  always_comb begin
    p_d = p_q;
    if (clr) begin
      p_d = even_parity(CLR_VALUE);
    end else begin
      p_d = even_parity(q_d);
    end
  end

  // Parity register, updated alongside the stages.
  always_ff @(posedge clk) begin
    p_q <= p_d;
  end
`endif

endmodule

// File: tb/tb_shift_reg4_sipo.sv
// Self-checking bench for shift_reg4_sipo: directed plan followed by random stimulus
// against an integer-arithmetic reference model.
module tb_shift_reg4_sipo;

  logic       clk;
  logic       clr;
  logic       load;
  logic [3:0] data;
  logic       ena;
  logic       a_in;
  logic [3:0] q_out;
  logic       e_out;
`ifdef SHIFTREG_PARITY_EN
  logic       p_out;
`endif

  int n_checks;
  int n_errors;
  int model;

  shift_reg4_sipo dut (
    .clk  (clk),
    .clr  (clr),
    .load (load),
    .data (data),
    .ena  (ena),
    .A    (a_in),
`ifdef SHIFTREG_PARITY_EN
    .P    (p_out),
`endif
    .Q    (q_out),
    .E    (e_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ones(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n = n + ((v >> i) & 1);
    return n;
  endfunction

  // Apply one cycle of controls, advance the model, compare everything visible.
  task automatic step(input string tag, input logic c, input logic l, input logic [3:0] d,
                      input logic en, input logic a);
    clr  = c;
    load = l;
    data = d;
    ena  = en;
    a_in = a;
    @(posedge clk);
    #1;
    if (c) model = 0;
    else if (l) model = int'(d);
    else if (en) model = (model / 2) + (a ? 8 : 0);
    check_eq({tag, ".Q"}, int'(q_out), model);
    check_eq({tag, ".E"}, int'(e_out), model % 2);
    check_eq({tag, ".B"}, int'(dut.B), (model / 8) % 2);
    check_eq({tag, ".C"}, int'(dut.C), (model / 4) % 2);
    check_eq({tag, ".D"}, int'(dut.D), (model / 2) % 2);
`ifdef SHIFTREG_PARITY_EN
    check_eq({tag, ".P"}, int'(p_out), ones(model) % 2);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model    = 0;
    clr = 1'b0; load = 1'b0; data = 4'b0000; ena = 1'b0; a_in = 1'b0;
    @(negedge clk);

    step("clr",        1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    step("load1101",   1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
    step("shiftA1",    1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    step("shiftA0",    1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step("load1010",   1'b0, 1'b1, 4'b1010, 1'b0, 1'b0);
    step("shift1010",  1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    step("loadwins",   1'b0, 1'b1, 4'b0011, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("hold",     1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
    step("clrwins",    1'b1, 1'b1, 4'b1111, 1'b1, 1'b1);
    step("reload1101", 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
    check_eq("plan.Q1101", int'(q_out), 13);

    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
